// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester/transmitter bundle for uart_tx_sched
//
// Purpose: groups the requester handshake and the uart_tx parallel bus.
// Signals:
//   req       requester -> sched  per-requester byte pending, held until ack
//   req_data  requester -> sched  requester i byte on [i*DATA_W +: DATA_W]
//   ack       sched -> requester  one-cycle pulse, byte taken
//   tx_data   sched -> uart_tx    byte for the current frame
//   tx_load   sched -> uart_tx    one-cycle frame start strobe
//   grant_id  sched -> observer   index of the most recent winner
//   busy      sched -> observer   frame or inter-frame gap in progress
// Modports: master = requester/observer side, slave = scheduler side.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_load;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport master (
    output req, req_data,
    input  ack, tx_data, tx_load, grant_id, busy
  );

  modport slave (
    input  req, req_data,
    output ack, tx_data, tx_load, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx between requesters
//
// Purpose: arbitrates NUM_REQ byte producers onto a single uart_tx, times
// each frame plus an inter-frame gap, and only re-arbitrates once idle.
// One i_baud_tick cycle equals one serial bit time.
// Ports:
//   i_baud_tick  clock, all logic on the rising edge
//   i_reset      asynchronous active-high reset
//   bus          uart_tx_sched_if.slave (req/req_data in; ack, tx_data,
//                tx_load, grant_id, busy out; all outputs registered)
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int FRAME_TICKS = 10,
  parameter int GAP_TICKS   = 1,
  parameter int ID_W        = 2
) (
  input logic             i_baud_tick,
  input logic             i_reset,
  uart_tx_sched_if.slave  bus
);

  localparam int CNT_MAX = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic                r_tx_load, w_tx_load_nxt;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_nxt;
  logic [ID_W-1:0]     r_grant_id, w_grant_id_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_found;
  logic [ID_W-1:0]     w_win;

  // Search starts just after the last winner, so the requester served last
  // has the lowest priority at the next arbitration.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_ack_nxt      = '0;
    w_tx_load_nxt  = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_grant_id_nxt = r_grant_id;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_tx_data_nxt  = bus.req_data[int'(w_win)*DATA_W +: DATA_W];
          w_grant_id_nxt = w_win;
          w_rr_ptr_nxt   = w_win;
          w_ack_nxt      = NUM_REQ'(1) << w_win;
          w_tx_load_nxt  = 1'b1;
          w_cnt_nxt      = CNT_W'(FRAME_TICKS - 1);
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_W'(GAP_TICKS - 1);
          w_state_nxt = GAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // busy is registered with the state so it reflects the state it enters.
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_baud_tick or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_ack      <= '0;
      r_tx_load  <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_load  <= w_tx_load_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.tx_load  = r_tx_load;
  assign bus.tx_data  = r_tx_data;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int FT = 10;
  localparam int GT = 1;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

  uart_tx_sched #(
    .NUM_REQ(NR), .DATA_W(DW), .FRAME_TICKS(FT), .GAP_TICKS(GT), .ID_W(IW)
  ) dut (
    .i_baud_tick(clk),
    .i_reset    (rst),
    .bus        (bus)
  );

  // Requester agents: a_keep=1 means present a fresh byte on ack and keep req.
  logic [NR-1:0]    a_req  = '0;
  logic [NR*DW-1:0] a_data = '0;
  logic [NR-1:0]    a_keep = '0;
  assign bus.req      = a_req;
  assign bus.req_data = a_data;

  // Reference model: one countdown of bit times until the next arbitration.
  int            m_ptr;
  int            m_hold;
  logic [NR-1:0] m_ack;
  logic          m_load;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_gid;
  logic          m_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int load_cyc[$];
  int load_gid[$];
  int load_dat[$];
  logic [NR-1:0] ack_or;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = NR - 1;
    m_hold = 0;
    m_ack  = '0;
    m_load = 1'b0;
    m_data = '0;
    m_gid  = '0;
    m_busy = 1'b0;
  endtask

  task automatic model_step();
    int w;
    m_ack  = '0;
    m_load = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (a_req != '0) begin
      for (int k = 1; k <= NR; k++) begin
        w = (m_ptr + k) % NR;
        if (a_req[w]) begin
          m_ack    = '0;
          m_ack[w] = 1'b1;
          m_load   = 1'b1;
          m_data   = a_data[w*DW +: DW];
          m_gid    = IW'(w);
          m_ptr    = w;
          m_hold   = FT + GT;
          break;
        end
      end
    end
    m_busy = (m_hold != 0);
  endtask

  task automatic clear_log();
    load_cyc.delete();
    load_gid.delete();
    load_dat.delete();
    ack_or = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    cyc++;
    check("ack",      32'(bus.ack),      32'(m_ack));
    check("tx_load",  32'(bus.tx_load),  32'(m_load));
    check("tx_data",  32'(bus.tx_data),  32'(m_data));
    check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check("busy",     32'(bus.busy),     32'(m_busy));
    if (bus.tx_load) begin
      load_cyc.push_back(cyc);
      load_gid.push_back(int'(bus.grant_id));
      load_dat.push_back(int'(bus.tx_data));
    end
    ack_or = ack_or | bus.ack;
    for (int i = 0; i < NR; i++) begin
      if (m_ack[i]) begin
        if (a_keep[i]) a_data[i*DW +: DW] = DW'($urandom);
        else           a_req[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    a_req  = '0;
    a_keep = '0;
    rst    = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int busy_cnt;

  initial begin
    model_reset();
    clear_log();

    // Reset state
    do_reset();
    check("rst_ack",  32'(bus.ack),      32'h0);
    check("rst_load", 32'(bus.tx_load),  32'h0);
    check("rst_data", 32'(bus.tx_data),  32'h0);
    check("rst_busy", 32'(bus.busy),     32'h0);

    // 1: single byte from requester 2
    a_req[2] = 1'b1;
    a_data[2*DW +: DW] = 8'h9B;
    clear_log();
    tick();
    check("t1_ack",  32'(bus.ack),      32'h4);
    check("t1_load", 32'(bus.tx_load),  32'h1);
    check("t1_data", 32'(bus.tx_data),  32'h9B);
    check("t1_gid",  32'(bus.grant_id), 32'h2);
    busy_cnt = bus.busy ? 1 : 0;
    repeat (20) begin
      tick();
      if (bus.busy) busy_cnt++;
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd11);
    check("t1_loads", 32'(load_cyc.size()), 32'd1);
    check("t1_acks",  32'(ack_or), 32'h4);

    // 2: all four requesting, each dropping on ack
    do_reset();
    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_req  = 4'hF;
    clear_log();
    repeat (60) tick();
    check("t2_loads", 32'(load_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < load_cyc.size(); i++) begin
      check("t2_gid",  32'(load_gid[i]), 32'(i));
      check("t2_data", 32'(load_dat[i]), 32'(8'hA0 + i));
      if (i > 0) check("t2_spacing", 32'(load_cyc[i] - load_cyc[i-1]), 32'd12);
    end
    check("t2_idle", 32'(bus.busy), 32'h0);

    // 3: fairness between requesters 0 and 3 under permanent demand
    do_reset();
    a_data[0*DW +: DW] = DW'($urandom);
    a_data[3*DW +: DW] = DW'($urandom);
    a_keep = 4'b1001;
    a_req  = 4'b1001;
    clear_log();
    repeat (50) tick();
    check("t3_loads", 32'(load_cyc.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < load_cyc.size(); i++) begin
      check("t3_gid", 32'(load_gid[i]), (i % 2 == 1) ? 32'd3 : 32'd0);
      if (i > 0) check("t3_spacing", 32'(load_cyc[i] - load_cyc[i-1]), 32'd12);
    end
    a_req  = '0;
    a_keep = '0;

    // 4: data changes after ack are ignored
    do_reset();
    a_data[1*DW +: DW] = 8'h55;
    a_req[1] = 1'b1;
    tick();
    check("t4_gid", 32'(bus.grant_id), 32'h1);
    tick();
    a_data[1*DW +: DW] = 8'hFF;
    repeat (15) begin
      tick();
      check("t4_hold", 32'(bus.tx_data), 32'h55);
    end

    // 5: asynchronous reset mid-frame, then round-robin pointer restart
    do_reset();
    a_data[2*DW +: DW] = 8'h3C;
    a_req[2] = 1'b1;
    tick();
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("t5_ack",  32'(bus.ack),      32'h0);
    check("t5_load", 32'(bus.tx_load),  32'h0);
    check("t5_data", 32'(bus.tx_data),  32'h0);
    check("t5_gid",  32'(bus.grant_id), 32'h0);
    check("t5_busy", 32'(bus.busy),     32'h0);
    model_reset();
    a_req = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    a_data[0*DW +: DW] = 8'h11;
    a_data[1*DW +: DW] = 8'h22;
    a_req = 4'b0011;
    tick();
    check("t5_first_gid", 32'(bus.grant_id), 32'h0);
    check("t5_first_ack", 32'(bus.ack),      32'h1);
    repeat (30) tick();

    // 6: withdrawn request during another requester's frame
    do_reset();
    a_data[2*DW +: DW] = 8'h66;
    a_req[2] = 1'b1;
    clear_log();
    tick();
    repeat (3) tick();
    a_data[1*DW +: DW] = 8'h77;
    a_req[1] = 1'b1;
    repeat (5) tick();
    a_req[1] = 1'b0;
    repeat (15) tick();
    check("t6_loads", 32'(load_cyc.size()), 32'd1);
    check("t6_ack1",  32'(ack_or[1]),       32'h0);
    check("t6_idle",  32'(bus.busy),        32'h0);

    // Randomized traffic with raises, withdrawals and back-to-back bytes
    do_reset();
    repeat (3000) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (!a_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            a_data[i*DW +: DW] = DW'($urandom);
            a_keep[i] = 1'($urandom_range(0, 1));
            a_req[i]  = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          a_req[i] = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one uart_tx serializer between NUM_REQ byte producers. It accepts one byte per requester through a req/ack handshake and drives the transmitter's parallel data bus with a one-cycle load strobe. It times each frame itself and holds off the next grant until the frame plus an inter-frame gap has elapsed. It runs on the baud tick, so one cycle equals one serial bit time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width, matches uart_tx data input
FRAME_TICKS, 10, bit times per frame (start + 8 data + stop); must be >= 1
GAP_TICKS, 1, idle bit times forced between frames; must be >= 1
ID_W, 2, width of grant_id; must be >= clog2(NUM_REQ)

Ports:
baud_tick  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
req  in  NUM_REQ  per-requester "byte pending"; held high until ack
req_data  in  NUM_REQ*DATA_W  requester i's byte on bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse to the granted requester; byte taken
tx_data  out  DATA_W  byte presented to uart_tx; stable for the whole frame
tx_load  out  1  one-cycle pulse; uart_tx starts a frame with tx_data
grant_id  out  ID_W  index of the most recent winner
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, async, any state: state=IDLE, ack=0, tx_load=0, tx_data=0, grant_id=0, busy=0, cnt=0, rr_ptr=NUM_REQ-1 (req[0] wins the first arbitration).
- Reset mid-frame: the in-flight byte is abandoned and no ack is reissued. A requester whose ack already pulsed does not resend.
- The FSM has three states: IDLE, SEND and GAP. All outputs are registered.
- IDLE, req==0: remain in IDLE. ack=0, tx_load=0.
- IDLE, req!=0, at edge E:
  - Winner w is the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Registered at E: tx_data<=req_data[w], grant_id<=w, rr_ptr<=w, ack<=onehot(w), tx_load<=1, cnt<=FRAME_TICKS-1, state<=SEND.
  - ack[w] and tx_load are therefore high exactly during the cycle after E.
- SEND:
  - ack and tx_load return to 0 after one cycle.
  - cnt decrements each edge. At the edge where cnt==0: cnt<=GAP_TICKS-1, state<=GAP.
  - tx_data is held.
- GAP: cnt decrements each edge. At the edge where cnt==0: state<=IDLE. tx_data is held.
- busy is high in SEND and GAP and low in IDLE. It is registered alongside the state.
- Throughput: a grant edge is followed FRAME_TICKS+GAP_TICKS+1 edges later by the next possible grant edge. With the defaults, tx_load pulses are 12 cycles apart under continuous demand.
- Handshake rules:
  - A requester holds req and req_data stable until it samples ack. It may deassert req, or present a new byte with req still high, in the cycle following ack.
  - req_data is sampled only at the grant edge. Changes at any other time are ignored.
  - No req is sampled outside IDLE, so a held req cannot be double-granted.
  - Dropping req before ack withdraws the request with no side effects.
- Fairness: after requester w is served, w has the lowest priority at the next arbitration. Under continuous all-requester demand, grants rotate 0,1,2,3,0,...
- Simultaneous events: reset asserted on a grant edge wins. No ack, no tx_load.
- grant_id and tx_data keep their last values in IDLE; they are not cleared after a frame.

Test Plan:
1. Single byte: reset, then req[2]=1 with data 8'h9B -> one grant edge; next cycle ack=4'b0100, tx_load=1, tx_data=8'h9B, grant_id=2; busy high for 11 cycles; ack/tx_load pulse exactly once.
2. All four requesting continuously (data 8'hA0..8'hA3), each dropping req on its ack -> tx_load pulses 12 cycles apart; grant_id sequence 0,1,2,3; tx_data sequence A0,A1,A2,A3; then busy=0.
3. Fairness: req[0] and req[3] held high permanently, each presenting a new byte after every ack -> grants alternate 0,3,0,3; neither requester waits more than one frame period.
4. Data stability: req[1] high with 8'h55; req_data[1] changed to 8'hFF in the cycle after ack -> tx_data stays 8'h55 until the next grant.
5. Reset mid-frame: assert reset 4 cycles into SEND -> outputs go to 0 immediately and asynchronously; after release with req[0]=1 -> first grant goes to 0.
6. Withdraw: req[1] high during SEND of another requester, dropped before IDLE -> requester 1 receives no ack, no extra tx_load occurs, and the scheduler returns to IDLE.
